// File: rtl/vga_console_pkg.sv
// Shared types and helpers for the VGA text console feeder: FSM states,
// ASCII control codes and the character-memory word packing.
package vga_console_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_e;

  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_BS = 8'h08;
  localparam logic [7:0] ASC_FF = 8'h0C;
  localparam logic [7:0] ASC_SP = 8'h20;

  // Colour mode drops bit 7 of the glyph to make room for the colour fields.
  function automatic logic [31:0] pack_char(input logic        use_color,
                                            input logic [11:0] fg,
                                            input logic [11:0] bg,
                                            input logic [7:0]  ch);
    return use_color ? {bg, fg, 1'b0, ch[6:0]} : {24'd0, ch};
  endfunction

endpackage

// File: rtl/vga_text_console.sv
// Byte-stream to character-memory writer: tracks a cursor, interprets
// LF/CR/BS/FF, wraps at the screen edge and clears every newly entered line.
module vga_text_console
  import vga_console_pkg::*;
#(
  parameter int COLS           = 80,
  parameter int ROWS           = 30,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  input  logic        use_color,
  input  logic [11:0] fg_rgb,
  input  logic [11:0] bg_rgb,
  output logic        char_we,
  output logic [11:0] char_addr,
  output logic [31:0] char_value,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_e      state_q;
  logic [4:0]  row_q, clr_row_q;
  logic [6:0]  col_q, clr_col_q;
  logic        uc_q;
  logic [11:0] fg_q, bg_q;
  logic        we_q;
  logic [11:0] addr_q;
  logic [31:0] value_q;

  logic [4:0] row_nxt;
  logic       printable;
  logic       accept;

  assign row_nxt   = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? CLR_SCREEN : IDLE;
      row_q     <= '0;
      col_q     <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
      uc_q      <= 1'b0;
      fg_q      <= '0;
      bg_q      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      value_q   <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // Colours are captured per byte so any clear it triggers matches it.
            uc_q <= use_color;
            fg_q <= fg_rgb;
            bg_q <= bg_rgb;
            if (printable) begin
              we_q    <= 1'b1;
              addr_q  <= {row_q, col_q};
              value_q <= pack_char(use_color, fg_rgb, bg_rgb, in_char);
              if (col_q == LAST_COL) begin
                col_q     <= '0;
                row_q     <= row_nxt;
                clr_row_q <= row_nxt;
                clr_col_q <= '0;
                state_q   <= CLR_LINE;
              end else begin
                col_q <= col_q + 7'd1;
              end
            end else if (in_char == ASC_LF) begin
              col_q     <= '0;
              row_q     <= row_nxt;
              clr_row_q <= row_nxt;
              clr_col_q <= '0;
              state_q   <= CLR_LINE;
            end else if (in_char == ASC_CR) begin
              col_q <= '0;
            end else if (in_char == ASC_BS) begin
              if (col_q != 7'd0) begin
                col_q   <= col_q - 7'd1;
                we_q    <= 1'b1;
                addr_q  <= {row_q, col_q - 7'd1};
                value_q <= pack_char(use_color, fg_rgb, bg_rgb, ASC_SP);
              end
            end else if (in_char == ASC_FF) begin
              row_q     <= '0;
              col_q     <= '0;
              clr_row_q <= '0;
              clr_col_q <= '0;
              state_q   <= CLR_SCREEN;
            end
          end
        end
        CLR_LINE: begin
          we_q    <= 1'b1;
          addr_q  <= {clr_row_q, clr_col_q};
          value_q <= pack_char(uc_q, fg_q, bg_q, ASC_SP);
          if (clr_col_q == LAST_COL) begin
            clr_col_q <= '0;
            state_q   <= IDLE;
          end else begin
            clr_col_q <= clr_col_q + 7'd1;
          end
        end
        CLR_SCREEN: begin
          we_q    <= 1'b1;
          addr_q  <= {clr_row_q, clr_col_q};
          value_q <= pack_char(uc_q, fg_q, bg_q, ASC_SP);
          if (clr_col_q == LAST_COL) begin
            clr_col_q <= '0;
            if (clr_row_q == LAST_ROW) begin
              clr_row_q <= '0;
              row_q     <= '0;
              col_q     <= '0;
              state_q   <= IDLE;
            end else begin
              clr_row_q <= clr_row_q + 5'd1;
            end
          end else begin
            clr_col_q <= clr_col_q + 7'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_we    = we_q;
  assign char_addr  = addr_q;
  assign char_value = value_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = ~in_ready;

endmodule

// File: tb/tb_vga_text_console.sv
// Directed + random bench for vga_text_console against a screen-array model.
module tb_vga_text_console;
  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_char = '0;
  logic        use_color = 1'b0;
  logic [11:0] fg_rgb = '0, bg_rgb = '0;
  logic        in_ready, char_we, busy;
  logic [11:0] char_addr;
  logic [31:0] char_value;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  vga_text_console #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .use_color(use_color), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .char_we(char_we),
    .char_addr(char_addr), .char_value(char_value), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy));

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  logic [31:0] mirror [4096];
  logic [31:0] model  [4096];
  int wcount = 0, badaddr = 0;
  int mr = 0, mc = 0;

  // Capture every memory write the DUT issues.
  always @(negedge clk) begin
    if (char_we) begin
      mirror[char_addr] = char_value;
      wcount++;
      if (int'(char_addr[6:0]) >= COLS || int'(char_addr[11:7]) >= ROWS) badaddr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pk(input logic uc, input logic [11:0] f, input logic [11:0] g,
                                     input logic [7:0] ch);
    return uc ? {g, f, 1'b0, ch[6:0]} : {24'd0, ch};
  endfunction

  task automatic m_nl(input logic uc, input logic [11:0] f, input logic [11:0] g);
    mc = 0;
    mr = (mr == ROWS - 1) ? 0 : mr + 1;
    for (int c = 0; c < COLS; c++) model[mr * 128 + c] = pk(uc, f, g, 8'h20);
  endtask

  task automatic m_cls(input logic uc, input logic [11:0] f, input logic [11:0] g);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r * 128 + c] = pk(uc, f, g, 8'h20);
    mr = 0; mc = 0;
  endtask

  task automatic m_apply(input logic [7:0] b, input logic uc, input logic [11:0] f,
                         input logic [11:0] g);
    if (b >= 8'h20 && b <= 8'h7E) begin
      model[mr * 128 + mc] = pk(uc, f, g, b);
      if (mc < COLS - 1) mc++;
      else m_nl(uc, f, g);
    end else if (b == 8'h0A) m_nl(uc, f, g);
    else if (b == 8'h0D) mc = 0;
    else if (b == 8'h08) begin
      if (mc > 0) begin mc--; model[mr * 128 + mc] = pk(uc, f, g, 8'h20); end
    end else if (b == 8'h0C) m_cls(uc, f, g);
  endtask

  function automatic int mism();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mirror[r * 128 + c] !== model[r * 128 + c]) n++;
    return n;
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [7:0] b, input logic uc, input logic [11:0] f,
                      input logic [11:0] g);
    int n = 0;
    in_valid = 1'b1; in_char = b; use_color = uc; fg_rgb = f; bg_rgb = g;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      @(negedge clk);
      m_apply(b, uc, f, g);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int w0, n, e1, e2;
    logic [7:0] ch;
    for (int i = 0; i < 4096; i++) begin mirror[i] = 32'hDEADBEEF; model[i] = 32'hDEADBEEF; end

    // Reset state
    #12;
    chk("rst_we", 32'(char_we), 32'd0);
    chk("rst_addr", 32'(char_addr), 32'd0);
    chk("rst_value", char_value, 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Power-up clear
    @(negedge clk);
    w0 = wcount;
    rst_n = 1'b1;
    m_cls(1'b0, 12'h0, 12'h0);
    wait_idle(n);
    #1;
    chk("cls_busy_cycles", 32'(n), 32'd2400);
    chk("cls_writes", 32'(wcount - w0), 32'd2400);
    chk("cls_badaddr", 32'(badaddr), 32'd0);
    chk("cls_content", 32'(mism()), 32'd0);
    chk("cls_cursor", {cursor_row, cursor_col}, 32'd0);
    @(negedge clk);

    // Plain and colour characters
    send(8'h41, 1'b0, 12'h000, 12'h000);
    chk("A_we", 32'(char_we), 32'd1);
    chk("A_addr", 32'(char_addr), 32'h000);
    chk("A_value", char_value, 32'h00000041);
    chk("A_col", 32'(cursor_col), 32'd1);
    @(negedge clk);
    chk("idle_we_low", 32'(char_we), 32'd0);
    send(8'h42, 1'b1, 12'hFFF, 12'h00F);
    chk("B_addr", 32'(char_addr), 32'h001);
    chk("B_value", char_value, 32'h00FFFF42);

    // CR then a full row back-to-back, forcing the wrap and line clear
    send(8'h0D, 1'b0, 12'h0, 12'h0);
    chk("CR_no_write", 32'(char_we), 32'd0);
    chk("CR_col", 32'(cursor_col), 32'd0);
    e1 = 0;
    for (int i = 0; i < COLS; i++) begin
      ch = 8'($urandom_range(32, 126));
      if (!in_ready) e1++;
      in_valid = 1'b1; in_char = ch; use_color = 1'b0;
      @(negedge clk);
      if (!(char_we === 1'b1 && char_addr === 12'(i) && char_value === {24'd0, ch})) e1++;
      m_apply(ch, 1'b0, 12'h0, 12'h0);
    end
    in_valid = 1'b0;
    chk("b2b_row_errors", 32'(e1), 32'd0);
    e2 = 0;
    for (int k = 1; k <= COLS; k++) begin
      @(negedge clk);
      if (!(char_we === 1'b1 && char_addr === 12'(12'h080 + k - 1) && char_value === 32'h20)) e2++;
      if (k < COLS && in_ready !== 1'b0) e2++;
    end
    chk("line_clear_errors", 32'(e2), 32'd0);
    chk("line_clear_ready", 32'(in_ready), 32'd1);
    chk("wrap_cursor", {cursor_row, cursor_col}, {20'd0, 5'd1, 7'd0});
    #1;
    chk("wrap_content", 32'(mism()), 32'd0);

    // Row wrap from the last row back to row 0
    for (int i = 0; i < ROWS - 2; i++) begin send(8'h0A, 1'b0, 12'h0, 12'h0); wait_idle(n); end
    chk("row29", 32'(cursor_row), 32'd29);
    send(8'h0A, 1'b0, 12'h0, 12'h0);
    wait_idle(n);
    #1;
    chk("lastrow_wrap_cursor", {cursor_row, cursor_col}, 32'd0);
    chk("lastrow_wrap_content", 32'(mism()), 32'd0);
    @(negedge clk);

    // Backspace at and away from column 0
    send(8'h08, 1'b0, 12'h0, 12'h0);
    chk("BS0_no_write", 32'(char_we), 32'd0);
    chk("BS0_col", 32'(cursor_col), 32'd0);
    send(8'h78, 1'b0, 12'h0, 12'h0);
    send(8'h79, 1'b0, 12'h0, 12'h0);
    send(8'h7A, 1'b0, 12'h0, 12'h0);
    send(8'h08, 1'b1, 12'h123, 12'h456);
    chk("BS_we", 32'(char_we), 32'd1);
    chk("BS_addr", 32'(char_addr), 32'h002);
    chk("BS_value", char_value, 32'h45612320);
    chk("BS_col", 32'(cursor_col), 32'd2);

    // Random byte stream; senders hold bytes while the DUT is busy
    e1 = 0;
    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 70) ch = 8'($urandom_range(32, 126));
      else if (kind < 80) ch = 8'h0A;
      else if (kind < 85) ch = 8'h0D;
      else if (kind < 93) ch = 8'h08;
      else if (kind < 95) ch = 8'h0C;
      else begin
        ch = 8'h0A;
        while ((ch >= 8'h20 && ch <= 8'h7E) || ch == 8'h0A || ch == 8'h0D ||
               ch == 8'h08 || ch == 8'h0C)
          ch = 8'($urandom_range(0, 255));
      end
      send(ch, 1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom));
      if (int'(cursor_row) != mr || int'(cursor_col) != mc) e1++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle(n);
    #1;
    chk("rand_cursor_errors", 32'(e1), 32'd0);
    chk("rand_content", 32'(mism()), 32'd0);
    chk("rand_badaddr", 32'(badaddr), 32'd0);
    @(negedge clk);

    // Reset during a screen clear, with a byte offered throughout
    send(8'h0C, 1'b1, 12'hABC, 12'h321);
    repeat (100) @(negedge clk);
    in_valid = 1'b1; in_char = 8'h5A;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(char_we), 32'd0);
    chk("midrst_cursor", {cursor_row, cursor_col}, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    m_cls(1'b0, 12'h0, 12'h0);
    n = 0;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    chk("midrst_reclear_cycles", 32'(n), 32'd2400);
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_final_cursor", {cursor_row, cursor_col}, 32'd0);
    chk("midrst_content", 32'(mism()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
